reg_dump_streamer: RTL

REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

---
 rtl/reg_dump_streamer.sv | 105 ++++++++++
 1 files changed

// File: rtl/reg_dump_streamer.sv
// Streams a sync byte followed by registers FIRST_REG..LAST_REG, each word sent
// least-significant byte first, over a valid/ready byte interface.
module reg_dump_streamer #(
  parameter logic [4:0] FIRST_REG = 5'd0,
  parameter logic [4:0] LAST_REG  = 5'd31,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  output logic [4:0]  oRegSel,
  input  logic [31:0] iRegData,
  output logic [7:0]  oData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [2:0] {IDLE, HEAD, LOAD, SEND, FIN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [1:0]  k, k_nxt;
  logic [31:0] buffer, buffer_nxt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state  <= IDLE;
      idx    <= FIRST_REG;
      k      <= '0;
      buffer <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      k      <= k_nxt;
      buffer <= buffer_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    k_nxt      = k;
    buffer_nxt = buffer;
    oData      = '0;
    oValid     = 1'b0;
    oBusy      = 1'b0;
    oDone      = 1'b0;

    case (state)
      IDLE: begin
        if (iStart) begin
          idx_nxt   = FIRST_REG;
          state_nxt = HEAD;
        end
      end

      HEAD: begin
        oData  = HEADER;
        oValid = 1'b1;
        oBusy  = 1'b1;
        if (iReady) state_nxt = LOAD;
      end

      LOAD: begin
        oBusy      = 1'b1;
        buffer_nxt = iRegData;
        k_nxt      = '0;
        state_nxt  = SEND;
      end

      SEND: begin
        oBusy  = 1'b1;
        oValid = 1'b1;
        oData  = buffer[{k, 3'b000} +: 8];
        if (iReady) begin
          k_nxt = k + 2'd1;
          // Compare before incrementing so LAST_REG=31 never wraps to 0.
          if (k == 2'd3) begin
            if (idx == LAST_REG) begin
              state_nxt = FIN;
            end else begin
              idx_nxt   = idx + 5'd1;
              state_nxt = LOAD;
            end
          end
        end
      end

      FIN: begin
        oDone     = 1'b1;
        idx_nxt   = FIRST_REG;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign oRegSel = idx;

endmodule
